fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter DEPTH, default 4, instruction queue entries (power of two, >=2).
REQ-002 Parameter RESET_PC, default 32'h0, first fetch address after reset.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 imem_req  output  1  fetch request valid.
REQ-006 imem_addr  output  32  byte address of requested word, always word-aligned.
REQ-007 imem_gnt  input  1  request accepted this cycle (handshake completes when imem_req & imem_gnt).
REQ-008 imem_rvalid  input  1  read data valid; responses return in request order, >=1 cycle after grant.
REQ-009 imem_rdata  input  32  instruction word.
REQ-010 ifid_valid  output  1  queue head holds a valid instruction.
REQ-011 ifid_ir  output  32  head instruction; 32'h0 (no_op) when ifid_valid=0.
REQ-012 ifid_pc  output  32  byte address of head instruction; 0 when ifid_valid=0.
REQ-013 ifid_ready  input  1  decode consumes head this cycle (low during load-use stall).
REQ-014 redirect  input  1  taken branch / jump / mispredict: refetch from redirect_pc.
REQ-015 redirect_pc  input  32  new fetch address; bits [1:0] ignored (forced 0).

Function
REQ-016 fetch_pc SHALL drive imem_addr and advance by 4 on each granted request, wrapping modulo 2^32.
REQ-017 imem_req SHALL assert only when occupancy + outstanding < DEPTH, guaranteeing every response has a queue slot.
REQ-018 While imem_req=1 and imem_gnt=0, imem_addr SHALL hold stable unless redirect is asserted.
REQ-019 outstanding SHALL count granted-but-unanswered requests: +1 on grant, -1 on rvalid, net 0 when both.
REQ-020 A non-stale response SHALL be written to the queue tail with its PC in the same edge; visible at ifid_* next cycle (1-cycle rvalid-to-ifid_valid latency).
REQ-021 Pop SHALL occur when ifid_valid & ifid_ready; simultaneous push and pop SHALL be legal at any occupancy including full.
REQ-022 On redirect: queue emptied, fetch_pc <= {redirect_pc[31:2],2'b00}, discard_cnt <= outstanding after this cycle's grant/rvalid accounting; new requests permitted the next cycle.
REQ-023 A response arriving while discard_cnt>0 SHALL be dropped and decrement discard_cnt; it SHALL NOT enter the queue.
REQ-024 A response arriving in the same cycle as redirect SHALL be dropped; a grant in the same cycle as redirect SHALL be counted stale.
REQ-025 Redirect and pop in the same cycle: redirect wins, pop has no additional effect.
REQ-026 Redirect while queue empty and outstanding=0: no discards; first request to redirect_pc in next cycle.
REQ-027 ifid_ir/ifid_pc SHALL be combinational from the head entry, gated to 0 when empty.

Reset
REQ-028 reset_n low SHALL immediately force: fetch_pc=RESET_PC, occupancy=0, outstanding=0, discard_cnt=0, imem_req=0, ifid_valid=0, ifid_ir=0, ifid_pc=0.
REQ-029 First imem_req SHALL assert on the first rising edge after reset_n deasserts; responses arriving mid-reset SHALL be ignored.

Structure
REQ-030 Shared package cpu_pkg SHALL hold NO_OP (32'h0), opcode constants (LW, SW, BEQ, ALUop), and default DEPTH.
REQ-031 Queue storage SHALL be a sub-module fetch_fifo (DEPTH x 64 bits: pc, ir; push, pop, full, empty, count).
REQ-032 Counters SHALL be sized $clog2(DEPTH)+1 bits to represent 0..DEPTH.

Verification
REQ-033 Reset, gnt=1, rvalid 1 cycle after grant, ifid_ready=1 -> ifid_pc sequence 0,4,8,12 with ifid_ir = imem words 0..3, one per cycle after 2-cycle start-up.
REQ-034 ifid_ready=0 for 10 cycles -> exactly 4 grants, queue full, imem_req=0; ready=1 -> pcs 0,4,8,12 delivered in order, no loss.
REQ-035 2 outstanding requests (pc 16,20), redirect to 32'h100 -> both responses dropped, next ifid_pc=32'h100 then 32'h104.
REQ-036 redirect_pc=32'h203 -> imem_addr=32'h200.
REQ-037 redirect coincident with rvalid and pop -> queue empty next cycle, ifid_ir=0, no stale entry ever observed.
REQ-038 reset_n asserted with 3 queued + 1 outstanding -> outputs zero asynchronously; after release fetch restarts at RESET_PC and the late response is ignored.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: no-op encoding, base opcodes, default queue depth
// and the packed layout of one instruction-queue entry.
package cpu_pkg;

  localparam logic [31:0] NO_OP         = 32'h0000_0000;
  localparam logic [6:0]  OPC_LW        = 7'b000_0011;
  localparam logic [6:0]  OPC_SW        = 7'b010_0011;
  localparam logic [6:0]  OPC_BEQ       = 7'b110_0011;
  localparam logic [6:0]  OPC_ALUOP     = 7'b011_0011;
  localparam int          DEFAULT_DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction queue: DEPTH entries of {pc, ir}. Flush empties it; a pop and
// a push in the same cycle are accepted even when the queue is full.
import cpu_pkg::*;

module fetch_fifo #(
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  push_entry,
  output fetch_entry_t  head_entry,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          pop_en_s;
  logic          push_en_s;

  assign empty      = (count_q == CW'(0));
  assign full       = (count_q == CW'(DEPTH));
  assign count      = count_q;
  assign head_entry = mem_q[rd_ptr_q];
  assign pop_en_s   = pop & ~empty;
  assign push_en_s  = push & (~full | pop_en_s);

  // Pointer and occupancy bookkeeping; flush discards everything.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en_s) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_en_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push_en_s) - CW'(pop_en_s);
    end
  end

  // Entry storage; contents are only meaningful while counted as occupied.
  always_ff @(posedge clock) begin
    if (push_en_s && !flush) mem_q[wr_ptr_q] <= push_entry;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues in-order word requests, drops responses made stale
// by a redirect, and buffers good instructions for decode.
import cpu_pkg::*;

module fetch_unit #(
  parameter int          DEPTH    = DEFAULT_DEPTH,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        ifid_valid,
  output logic [31:0] ifid_ir,
  output logic [31:0] ifid_pc,
  input  logic        ifid_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = CW + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] disc_q, disc_d;
  logic          req_en_q;

  logic          grant_s, resp_s, push_s, pop_s;
  logic          fifo_full_s, fifo_empty_s;
  logic [CW-1:0] fifo_count_s;
  logic [SW-1:0] budget_s;
  fetch_entry_t  push_entry_s, head_entry_s;

  // A request is only issued when every in-flight response is sure of a slot.
  assign budget_s  = SW'(fifo_count_s) + SW'(out_q);
  assign imem_req  = req_en_q & ~fifo_full_s & (budget_s < SW'(DEPTH));
  assign imem_addr = fetch_pc_q;
  assign grant_s   = imem_req & imem_gnt;
  // A response with nothing outstanding is a leftover from before reset.
  assign resp_s    = imem_rvalid & (out_q != CW'(0));
  assign push_s    = resp_s & ~redirect & (disc_q == CW'(0));
  assign pop_s     = ifid_valid & ifid_ready & ~redirect;

  assign push_entry_s = '{pc: resp_pc_q, ir: imem_rdata};

  assign ifid_valid = ~fifo_empty_s;
  assign ifid_ir    = ifid_valid ? head_entry_s.ir : NO_OP;
  assign ifid_pc    = ifid_valid ? head_entry_s.pc : 32'h0000_0000;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .push       (push_s),
    .pop        (pop_s),
    .flush      (redirect),
    .push_entry (push_entry_s),
    .head_entry (head_entry_s),
    .full       (fifo_full_s),
    .empty      (fifo_empty_s),
    .count      (fifo_count_s)
  );

  // Next fetch/response PCs and in-flight accounting; a redirect turns every
  // request still in flight after this cycle into one to be discarded.
  always_comb begin
    out_d      = out_q + CW'(grant_s) - CW'(resp_s);
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    disc_d     = disc_q;
    if (redirect) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      resp_pc_d  = {redirect_pc[31:2], 2'b00};
      disc_d     = out_d;
    end else begin
      if (grant_s) fetch_pc_d = fetch_pc_q + 32'd4;
      if (push_s)  resp_pc_d  = resp_pc_q + 32'd4;
      if (resp_s && (disc_q != CW'(0))) disc_d = disc_q - CW'(1);
    end
  end

  // State registers; requests are enabled from the first edge after reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      out_q      <= '0;
      disc_q     <= '0;
      req_en_q   <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_q      <= out_d;
      disc_q     <= disc_d;
      req_en_q   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: the bench acts as instruction memory and keeps a
// transaction-level model (queue of delivered instructions, list of requests
// in flight tagged stale or not) that predicts every output each cycle.
module tb_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clock;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        ifid_valid;
  logic [31:0] ifid_ir;
  logic [31:0] ifid_pc;
  logic        ifid_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  int vectors;
  int miscompares;

  // Model state
  logic [31:0] m_q_pc[$];
  logic [31:0] m_q_ir[$];
  logic [31:0] p_addr[$];
  bit          p_stale[$];
  logic [31:0] m_pc;
  bit          m_reqen;

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .ifid_valid  (ifid_valid),
    .ifid_ir     (ifid_ir),
    .ifid_pc     (ifid_pc),
    .ifid_ready  (ifid_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    bit v;
    bit er;
    v  = (m_q_pc.size() != 0);
    er = m_reqen && ((m_q_pc.size() + p_addr.size()) < DEPTH);
    chk("ifid_valid", {31'd0, ifid_valid}, {31'd0, v});
    chk("ifid_pc", ifid_pc, v ? m_q_pc[0] : 32'h0);
    chk("ifid_ir", ifid_ir, v ? m_q_ir[0] : 32'h0);
    chk("imem_req", {31'd0, imem_req}, {31'd0, er});
    chk("imem_addr", imem_addr, m_pc);
  endtask

  // One clock cycle: drive inputs (called at a falling edge), apply the
  // cycle's effects to the model at the rising edge, check at the next fall.
  task automatic cycle(input bit g, input bit rd, input bit rdr, input bit rv,
                       input logic [31:0] rpc);
    bit          exp_req;
    bit          do_rv;
    bit          s;
    logic [31:0] a;
    exp_req     = m_reqen && ((m_q_pc.size() + p_addr.size()) < DEPTH);
    do_rv       = rv && (p_addr.size() != 0);
    imem_gnt    = g;
    ifid_ready  = rd;
    redirect    = rdr;
    redirect_pc = rpc;
    imem_rvalid = do_rv;
    imem_rdata  = do_rv ? word(p_addr[0]) : $urandom;
    @(posedge clock);
    if ((m_q_pc.size() != 0) && rd && !rdr) begin
      void'(m_q_pc.pop_front());
      void'(m_q_ir.pop_front());
    end
    if (do_rv) begin
      a = p_addr.pop_front();
      s = p_stale.pop_front();
      if (!s && !rdr) begin
        m_q_pc.push_back(a);
        m_q_ir.push_back(word(a));
      end
    end
    if (exp_req && g) begin
      p_addr.push_back(m_pc);
      p_stale.push_back(1'b0);
      m_pc = m_pc + 32'd4;
    end
    if (rdr) begin
      m_q_pc.delete();
      m_q_ir.delete();
      foreach (p_stale[i]) p_stale[i] = 1'b1;
      m_pc = {rpc[31:2], 2'b00};
    end
    m_reqen = 1'b1;
    @(negedge clock);
    check_model();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    m_pc        = RESET_PC;
    m_reqen     = 1'b0;
    reset_n     = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    ifid_ready  = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;

    // Reset state (response during reset must be ignored)
    repeat (2) @(negedge clock);
    check_model();
    reset_n = 1'b1;
    imem_rvalid = 1'b0;
    @(posedge clock);
    m_reqen = 1'b1;
    @(negedge clock);
    check_model();

    // Streaming: grant always, respond next cycle, decode always ready
    repeat (8) cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'h0);

    // Decode stalled: queue fills, requests stop, then drains in order
    repeat (10) cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
    chk("full_no_req", {31'd0, imem_req}, 32'h0);
    chk("full_valid", {31'd0, ifid_valid}, 32'h1);
    repeat (8) cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'h0);

    // Build up outstanding requests, then redirect to 0x100
    repeat (2) cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0100);
    chk("redir_addr", imem_addr, 32'h0000_0100);
    repeat (8) cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'h0);

    // Unaligned redirect target
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0203);
    chk("redir_align", imem_addr, 32'h0000_0200);
    repeat (4) cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);

    // Redirect together with response and pop
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0400);
    chk("redir_pop_empty", {31'd0, ifid_valid}, 32'h0);
    chk("redir_pop_ir", ifid_ir, 32'h0);
    repeat (6) cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'h0);

    // Randomized traffic, including wrap near the top of the address space
    for (int i = 0; i < 300; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 11) == 0, $urandom_range(0, 2) != 0,
            (i == 150) ? 32'hFFFF_FFF6 : $urandom);
    end
    repeat (10) cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'h0);

    // Three queued, one outstanding, then asynchronous reset
    for (int i = 0; i < 20; i++) begin
      if ((m_q_pc.size() == 3) && (p_addr.size() == 1)) break;
      cycle(1'b1, 1'b0, 1'b0, m_q_pc.size() < 3, 32'h0);
    end
    chk("pre_reset_q", m_q_pc.size(), 32'd3);
    #2;
    reset_n = 1'b0;
    #1;
    m_q_pc.delete();
    m_q_ir.delete();
    p_addr.delete();
    p_stale.delete();
    m_pc    = RESET_PC;
    m_reqen = 1'b0;
    check_model();
    imem_gnt    = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD0_BAD0;
    @(negedge clock);
    check_model();
    reset_n = 1'b1;
    @(posedge clock);
    m_reqen = 1'b1;
    @(negedge clock);
    imem_rvalid = 1'b0;
    check_model();
    repeat (10) cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
